// File: rtl/draw_layer_scheduler_if.sv
// Bundles the layer-side and VGA-side signals of the draw layer scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; drawers are paced by layer_en/layer_done levels.
// Ports (master = scheduler side):
//   in : go, layer_mask, transp_mask, layer_done, layer_x/y/color, layer_we
//   out: layer_en, X_out, Y_out, Color_out, writeEn, busy, frame_done,
//        timeout_err, cur_layer
interface draw_layer_scheduler_if #(
  parameter int NUM_LAYERS = 6
);
  logic                     go;
  logic [NUM_LAYERS-1:0]    layer_mask;
  logic [NUM_LAYERS-1:0]    transp_mask;
  logic [NUM_LAYERS-1:0]    layer_done;
  logic [9*NUM_LAYERS-1:0]  layer_x;
  logic [8*NUM_LAYERS-1:0]  layer_y;
  logic [12*NUM_LAYERS-1:0] layer_color;
  logic [NUM_LAYERS-1:0]    layer_we;
  logic [NUM_LAYERS-1:0]    layer_en;
  logic [8:0]               X_out;
  logic [7:0]               Y_out;
  logic [11:0]              Color_out;
  logic                     writeEn;
  logic                     busy;
  logic                     frame_done;
  logic                     timeout_err;
  logic [2:0]               cur_layer;

  modport master (
    input  go, layer_mask, transp_mask, layer_done,
           layer_x, layer_y, layer_color, layer_we,
    output layer_en, X_out, Y_out, Color_out, writeEn,
           busy, frame_done, timeout_err, cur_layer
  );

  modport slave (
    output go, layer_mask, transp_mask, layer_done,
           layer_x, layer_y, layer_color, layer_we,
    input  layer_en, X_out, Y_out, Color_out, writeEn,
           busy, frame_done, timeout_err, cur_layer
  );
endinterface

// File: rtl/draw_layer_scheduler.sv
// Frame sequencer: runs each unmasked layer in index order and muxes its pixels to VGA.
// Latency: pixel path 1 cycle; empty frame ends NUM_LAYERS+2 cycles after go.
// Backpressure: none; a layer runs until its done or the TIMEOUT bound, go ignored while busy.
// Ports: clk, resetn (async active-low), bus (draw_layer_scheduler_if.master).
module draw_layer_scheduler #(
  parameter int NUM_LAYERS = 6,
  parameter int TIMEOUT    = 100000,
  parameter int TO_W       = 17
) (
  input logic                   clk,
  input logic                   resetn,
  draw_layer_scheduler_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_RUN, S_GAP, S_DONE} state_t;

  state_t                state;
  logic [3:0]            idx;   // one wider than needed so it can reach NUM_LAYERS
  logic [NUM_LAYERS-1:0] mask_q;
  logic [NUM_LAYERS-1:0] transp_q;
  logic [TO_W-1:0]       cnt;

  logic [8:0]  x_q;
  logic [7:0]  y_q;
  logic [11:0] color_q;
  logic        we_q;
  logic        busy_q;
  logic        frame_done_q;
  logic        timeout_err_q;

  // Active-layer selection; idx==NUM_LAYERS selects nothing.
  logic [8:0]  sel_x;
  logic [7:0]  sel_y;
  logic [11:0] sel_color;
  logic        sel_we, sel_done, sel_transp, sel_mask;

  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_color  = '0;
    sel_we     = 1'b0;
    sel_done   = 1'b0;
    sel_transp = 1'b0;
    sel_mask   = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (idx == 4'(i)) begin
        sel_x      = bus.layer_x[9*i +: 9];
        sel_y      = bus.layer_y[8*i +: 8];
        sel_color  = bus.layer_color[12*i +: 12];
        sel_we     = bus.layer_we[i];
        sel_done   = bus.layer_done[i];
        sel_transp = transp_q[i];
        sel_mask   = mask_q[i];
      end
    end
  end

  always_comb begin
    bus.layer_en = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      bus.layer_en[i] = (state == S_RUN) && (idx == 4'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      idx           <= '0;
      mask_q        <= '0;
      transp_q      <= '0;
      cnt           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      color_q       <= '0;
      we_q          <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      we_q         <= 1'b0;

      // Pixel forwarding, including the cycle in which done is sampled.
      // Transparency looks at the incoming color, not the registered one.
      if (state == S_RUN) begin
        x_q     <= sel_x;
        y_q     <= sel_y;
        color_q <= sel_color;
        we_q    <= sel_we & ~(sel_transp & (sel_color == 12'h000));
      end

      case (state)
        S_IDLE: begin
          if (bus.go) begin
            mask_q        <= bus.layer_mask;
            transp_q      <= bus.transp_mask;
            idx           <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (idx == 4'(NUM_LAYERS)) begin
            frame_done_q <= 1'b1;
            state        <= S_DONE;
          end else if (sel_mask) begin
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_RUN: begin
          if (sel_done || cnt == TO_W'(TIMEOUT - 1)) begin
            if (!sel_done) timeout_err_q <= 1'b1;
            idx   <= idx + 4'd1;
            state <= S_GAP;
          end else begin
            // Leaving at TIMEOUT-1 means the counter saturates there.
            cnt <= cnt + TO_W'(1);
          end
        end
        S_GAP: begin
          state <= S_SCAN;
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.X_out       = x_q;
  assign bus.Y_out       = y_q;
  assign bus.Color_out   = color_q;
  assign bus.writeEn     = we_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.cur_layer   = idx[2:0];
endmodule

// File: tb/tb_draw_layer_scheduler.sv
module tb_draw_layer_scheduler;
  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  draw_layer_scheduler_if #(.NUM_LAYERS(6)) bus ();

  draw_layer_scheduler #(.NUM_LAYERS(6), .TIMEOUT(16), .TO_W(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural drawers: when auto_on, layer i raises done on its
  // done_after-th enabled cycle. man_done adds directed pulses.
  logic       auto_on;
  int         done_after;
  logic [5:0] man_done;
  logic [5:0] auto_done;
  int         en_cnt [6];

  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) en_cnt[i] <= bus.layer_en[i] ? en_cnt[i] + 1 : 0;
  end

  always_comb begin
    auto_done = '0;
    for (int i = 0; i < 6; i++)
      auto_done[i] = auto_on && bus.layer_en[i] && (en_cnt[i] == done_after - 1);
  end

  assign bus.layer_done = auto_done | man_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("wait_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  // Layer 1 streams four colors with we=1; exp_we is the writeEn sequence.
  task automatic run_transp(input logic transp_bit, input logic [3:0] exp_we);
    logic [11:0] colors [4];
    colors[0] = 12'h000; colors[1] = 12'hF00; colors[2] = 12'h000; colors[3] = 12'h0F0;
    bus.layer_mask  = 6'b000010;
    bus.transp_mask = {4'b0, transp_bit, 1'b0};
    bus.go = 1'b1;                       // cycle 0
    tick(); bus.go = 1'b0;               // cycle 1: SCAN idx0
    tick();                              // cycle 2: SCAN idx1
    tick();                              // cycle 3: RUN layer 1
    chk("tr_en", {26'd0, bus.layer_en}, 32'h2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        tick();
        chk($sformatf("tr_we%0d_t%0d", k - 1, transp_bit), {31'd0, bus.writeEn}, {31'd0, exp_we[3-(k-1)]});
      end
      bus.layer_color[23:12] = colors[k];
      bus.layer_we = 6'b000010;
      if (k == 3) man_done = 6'b000010;
    end
    tick();                              // GAP: last pixel of the run still written
    chk($sformatf("tr_we3_t%0d", transp_bit), {31'd0, bus.writeEn}, {31'd0, exp_we[0]});
    chk("tr_gap_en", {26'd0, bus.layer_en}, 32'h0);
    man_done = '0;
    bus.layer_we = '0;
    tick();
    chk("tr_we_off", {31'd0, bus.writeEn}, 32'd0);
    chk("tr_color_hold", {20'd0, bus.Color_out}, 32'h0F0);
    wait_idle(30);
  endtask

  int en3_count;

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    auto_on = 1'b0;
    done_after = 3;
    man_done = '0;
    bus.go = 1'b0;
    bus.layer_mask = '0;
    bus.transp_mask = '0;
    bus.layer_x = '0;
    bus.layer_y = '0;
    bus.layer_color = '0;
    bus.layer_we = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_en", {26'd0, bus.layer_en}, 32'd0);
    chk("rst_we", {31'd0, bus.writeEn}, 32'd0);
    chk("rst_cur", {29'd0, bus.cur_layer}, 32'd0);
    resetn = 1'b1;
    tick();

    // Empty frame: busy cycles 1..8, frame_done only at cycle 8
    bus.go = 1'b1;
    bus.layer_mask = 6'b000000;
    chk("empty_busy_c0", {31'd0, bus.busy}, 32'd0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) bus.go = 1'b0;
      chk($sformatf("empty_busy_c%0d", c), {31'd0, bus.busy}, {31'd0, (c <= 8)});
      chk($sformatf("empty_fd_c%0d", c), {31'd0, bus.frame_done}, {31'd0, (c == 8)});
      chk($sformatf("empty_we_c%0d", c), {31'd0, bus.writeEn}, 32'd0);
      if (c == 8) chk("empty_cur_c8", {29'd0, bus.cur_layer}, 32'd6);
    end

    // Layers 0 and 4, drawers finish on their 3rd enabled cycle
    bus.layer_x[8:0]   = 9'h1A5;
    bus.layer_x[44:36] = 9'h0F3;
    auto_on = 1'b1;
    done_after = 3;
    bus.layer_mask = 6'b010001;
    bus.go = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      logic [5:0] exp_en;
      tick();
      if (c == 1) bus.go = 1'b0;
      exp_en = (c >= 2 && c <= 4) ? 6'b000001 : (c >= 10 && c <= 12) ? 6'b010000 : 6'b000000;
      chk($sformatf("seq_en_c%0d", c), {26'd0, bus.layer_en}, {26'd0, exp_en});
      chk($sformatf("seq_fd_c%0d", c), {31'd0, bus.frame_done}, {31'd0, (c == 16)});
      if (c == 3)  chk("seq_x_l0", {23'd0, bus.X_out}, 32'h1A5);
      if (c == 11) chk("seq_x_l4", {23'd0, bus.X_out}, 32'h0F3);
      if (c == 14) chk("seq_x_hold", {23'd0, bus.X_out}, 32'h0F3);
      if (c == 17) chk("seq_busy_end", {31'd0, bus.busy}, 32'd0);
    end
    auto_on = 1'b0;

    // Transparency on layer 1
    run_transp(1'b1, 4'b0101);
    run_transp(1'b0, 4'b1111);

    // Layer 3 never finishes: timeout after 16 cycles
    bus.layer_mask = 6'b001000;
    bus.transp_mask = '0;
    bus.go = 1'b1;
    en3_count = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) bus.go = 1'b0;
      if (bus.layer_en[3]) en3_count++;
      if (c == 5)  chk("to_err_early", {31'd0, bus.timeout_err}, 32'd0);
      if (c == 10) chk("to_cur", {29'd0, bus.cur_layer}, 32'd3);
      if (c == 21) chk("to_err_gap", {31'd0, bus.timeout_err}, 32'd1);
    end
    chk("to_en_cycles", en3_count, 32'd16);
    chk("to_idle", {31'd0, bus.busy}, 32'd0);
    chk("to_sticky", {31'd0, bus.timeout_err}, 32'd1);
    bus.layer_mask = 6'b000000;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    chk("to_cleared", {31'd0, bus.timeout_err}, 32'd0);
    chk("to_busy2", {31'd0, bus.busy}, 32'd1);
    wait_idle(20);

    // go held through a frame, stray done on layer 4, mask change after go
    auto_on = 1'b1;
    done_after = 5;
    bus.layer_mask = 6'b000001;
    bus.go = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 4 || c == 5 || c == 6) chk($sformatf("hold_en_c%0d", c), {26'd0, bus.layer_en}, 32'h1);
      if (c == 7)  chk("hold_en_c7", {26'd0, bus.layer_en}, 32'h0);
      if (c == 9)  chk("hold_en_c9", {26'd0, bus.layer_en}, 32'h0);
      if (c == 13) chk("hold_fd_c13", {31'd0, bus.frame_done}, 32'd0);
      if (c == 14) chk("hold_fd_c14", {31'd0, bus.frame_done}, 32'd1);
      if (c == 14) chk("hold_busy_c14", {31'd0, bus.busy}, 32'd1);
      if (c == 15) chk("hold_busy_c15", {31'd0, bus.busy}, 32'd0);
      if (c == 16) chk("hold_busy_c16", {31'd0, bus.busy}, 32'd1);
      if (c == 16) chk("hold_cur_c16", {29'd0, bus.cur_layer}, 32'd0);
      if (c == 1)  bus.layer_mask = 6'b111111;
      if (c == 3)  man_done = 6'b010000;
      if (c == 4)  man_done = 6'b000000;
      if (c == 16) bus.go = 1'b0;
    end
    wait_idle(100);
    auto_on = 1'b0;

    // Reset in the middle of layer 2's run
    bus.layer_x[26:18]     = 9'h155;
    bus.layer_y[23:16]     = 8'h5A;
    bus.layer_color[35:24] = 12'hABC;
    bus.layer_we           = 6'b000100;
    bus.layer_mask         = 6'b000100;
    bus.go = 1'b1;
    tick(); bus.go = 1'b0;               // cycle 1
    tick(); tick(); tick();              // cycle 4: RUN layer 2
    tick();                              // cycle 5
    chk("mr_we_pre", {31'd0, bus.writeEn}, 32'd1);
    chk("mr_x_pre", {23'd0, bus.X_out}, 32'h155);
    chk("mr_en_pre", {26'd0, bus.layer_en}, 32'h4);
    resetn = 1'b0;
    tick();
    chk("mr_en", {26'd0, bus.layer_en}, 32'h0);
    chk("mr_busy", {31'd0, bus.busy}, 32'd0);
    chk("mr_x", {23'd0, bus.X_out}, 32'd0);
    chk("mr_y", {24'd0, bus.Y_out}, 32'd0);
    chk("mr_color", {20'd0, bus.Color_out}, 32'd0);
    chk("mr_we", {31'd0, bus.writeEn}, 32'd0);
    chk("mr_fd", {31'd0, bus.frame_done}, 32'd0);
    chk("mr_err", {31'd0, bus.timeout_err}, 32'd0);
    chk("mr_cur", {29'd0, bus.cur_layer}, 32'd0);
    resetn = 1'b1;
    bus.layer_we = '0;
    tick();
    chk("mr_stay_idle", {31'd0, bus.busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
